mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_AW, default 6, memory word-address width (64 words).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 if_req  in  1  instruction-fetch request; held until if_ack.
REQ-005 if_addr  in  32  fetch byte address; stable while if_req.
REQ-006 if_rdata / if_ack  out  32 / 1  fetch data; one-cycle completion pulse.
REQ-007 ls_req, ls_we  in  1, 1  load/store request; write when ls_we=1.
REQ-008 ls_addr, ls_wdata  in  32, 32  load/store byte address and store data; stable while ls_req.
REQ-009 ls_rdata / ls_ack / ls_err  out  32 / 1 / 1  load data; completion pulse; misalignment flag.
REQ-010 mem_en, mem_we  out  1, 1  memory access strobe and write enable.
REQ-011 mem_addr, mem_wdata  out  MEM_AW, 32  memory word address and write data.
REQ-012 mem_rdata  in  32  read data, valid the cycle after mem_en with mem_we=0.

Function
REQ-013 The block SHALL implement FSM states IDLE, ISSUE and RESP.
REQ-014 IDLE or RESP with a pending eligible request -> ISSUE; otherwise -> IDLE; ISSUE -> RESP always.
REQ-015 Arbitration runs in IDLE and RESP; one winner only; the winner's address, data and we SHALL be latched on the arbitration edge.
REQ-016 Single requester: it wins. Both requesting: the port not granted most recently wins (round-robin); last-grant pointer resets to if, so ls wins first contention.
REQ-017 In ISSUE, mem_en=1, mem_addr=latched addr[MEM_AW+1:2], mem_we=latched we (ls only), mem_wdata=latched wdata.
REQ-018 In RESP, winner's ack=1 for exactly one cycle; rdata = mem_rdata for reads; write acks carry rdata=0.
REQ-019 Latency: req sampled high at edge N -> mem_en high cycle N..N+1 -> ack high cycle N+1..N+2; peak throughput one access per 2 cycles.
REQ-020 A port's req in its own ack cycle SHALL NOT be arbitrated; that port is eligible again from the following cycle.
REQ-021 Misaligned address (addr[1:0]!=0) on ls: ISSUE SHALL keep mem_en=0; RESP asserts ls_ack and ls_err together; no write occurs. if_addr[1:0] ignored.
REQ-022 Address bits above MEM_AW+1 SHALL be discarded (wrap-around modulo 2^MEM_AW words).
REQ-023 if_rdata/ls_rdata SHALL hold the last delivered value between acks.
REQ-024 Outputs SHALL be registered; no combinational path req -> mem_en.

Reset
REQ-025 On rst: state IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, all acks/err=0, rdata outputs=0, last-grant=if.
REQ-026 Reset during ISSUE or RESP SHALL abandon the access with no ack; a write in ISSUE at the reset edge is not issued the following cycle.

Configuration
REQ-027 Macro LOADER_PORT_EN: when defined, adds ports ld_req (in 1), ld_addr (in 32), ld_wdata (in 32), ld_ack (out 1); write-only, fixed highest priority above round-robin, not updating last-grant; misaligned ld_addr is written at word addr[MEM_AW+1:2] without error.
REQ-028 Without LOADER_PORT_EN the ports SHALL not exist and behaviour is exactly REQ-013..REQ-026.

Structure
REQ-029 Shared package SHALL hold the FSM state enum (IDLE/ISSUE/RESP), port-id enum (IF/LS/LD) and the default MEM_AW constant.
REQ-030 The round-robin selector SHALL be a sub-module rr_arb2 (2 requests, last-grant in, one-hot grant out); the rest stays flat.

Verification
REQ-031 Read only: memory word 0=32'h00222000, if_req, if_addr=0 -> mem_en cycle 1, if_ack cycle 2, if_rdata=32'h00222000.
REQ-032 Contention: if_req and ls_req (read addr 8, word 2=32'h10E60001) same cycle -> ls_ack first (rdata 32'h10E60001), if_ack 2 cycles later; repeat -> if first.
REQ-033 Store: ls_we=1, ls_addr=12, ls_wdata=32'h1D090001 -> mem_we=1, mem_addr=3; then load addr 12 returns 32'h1D090001.
REQ-034 Misaligned: ls_addr=32'h0000_0006 -> mem_en stays 0, ls_ack=ls_err=1 cycle 2.
REQ-035 Wrap: if_addr=32'h0000_00BC (word 47) with MEM_AW=6 -> mem_addr=47; if_addr=32'h0000_0100 -> mem_addr=0.
REQ-036 rst asserted in ISSUE of a store -> no ack, all outputs 0 next cycle; with LOADER_PORT_EN, ld_req concurrent with ls_req wins first.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Used by mem_arbiter; the LOADER_PORT_EN build adds the LD port id to arbitration.
package mem_arbiter_pkg;

    localparam int MEM_AW_DEFAULT = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PORT_IF = 2'd0,
        PORT_LS = 2'd1,
        PORT_LD = 2'd2
    } port_e;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-request round-robin selector: grants the requester that did not win last.
// i_last = 0 means req[0] was granted most recently, 1 means req[1].
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    // one-hot grant; on contention favour the port not granted last
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one synchronous single-port memory between fetch (if) and load/store (ls).
// Optional macro LOADER_PORT_EN adds a write-only loader port with fixed top priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst,
`ifdef LOADER_PORT_EN
    input  logic              i_ld_req,
    input  logic [31:0]       i_ld_addr,
    input  logic [31:0]       i_ld_wdata,
    output logic              o_ld_ack,
`endif
    input  logic              i_if_req,
    input  logic [31:0]       i_if_addr,
    output logic [31:0]       o_if_rdata,
    output logic              o_if_ack,
    input  logic              i_ls_req,
    input  logic              i_ls_we,
    input  logic [31:0]       i_ls_addr,
    input  logic [31:0]       i_ls_wdata,
    output logic [31:0]       o_ls_rdata,
    output logic              o_ls_ack,
    output logic              o_ls_err,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    state_e            r_state;
    port_e             r_win;
    port_e             r_last;
    logic              r_rd;
    logic              r_mis;
    logic              r_if_ack;
    logic              r_ls_ack;
    logic              r_ls_err;
    logic              r_ld_ack;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_ls_rdata;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [MEM_AW-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic              w_ld_req;
    logic [31:0]       w_ld_addr;
    logic [31:0]       w_ld_wdata;
    logic              w_if_elig;
    logic              w_ls_elig;
    logic              w_ld_elig;
    logic [1:0]        w_gnt;
    logic              w_any;
    port_e             w_sel;
    logic [31:0]       w_addr;
    logic [31:0]       w_wdata;
    logic              w_we;
    logic              w_mis;
    logic              w_unused_bits;

`ifdef LOADER_PORT_EN
    assign w_ld_req   = i_ld_req;
    assign w_ld_addr  = i_ld_addr;
    assign w_ld_wdata = i_ld_wdata;
    assign o_ld_ack   = r_ld_ack;
`else
    assign w_ld_req   = 1'b0;
    assign w_ld_addr  = 32'd0;
    assign w_ld_wdata = 32'd0;
`endif

    // a port that is being acknowledged this cycle sits out this arbitration
    assign w_if_elig = i_if_req & ~r_if_ack;
    assign w_ls_elig = i_ls_req & ~r_ls_ack;
    assign w_ld_elig = w_ld_req & ~r_ld_ack;

    rr_arb2 u_rr_arb2 (
        .i_req  ({w_ls_elig, w_if_elig}),
        .i_last (r_last == PORT_LS),
        .o_gnt  (w_gnt)
    );

    // select the winning request and its access attributes
    always_comb begin
        w_any   = 1'b0;
        w_sel   = PORT_IF;
        w_addr  = i_if_addr;
        w_wdata = 32'd0;
        w_we    = 1'b0;
        w_mis   = 1'b0;
        if (w_ld_elig) begin
            w_any   = 1'b1;
            w_sel   = PORT_LD;
            w_addr  = w_ld_addr;
            w_wdata = w_ld_wdata;
            w_we    = 1'b1;
        end else if (w_gnt[1]) begin
            w_any   = 1'b1;
            w_sel   = PORT_LS;
            w_addr  = i_ls_addr;
            w_wdata = i_ls_wdata;
            w_we    = i_ls_we;
            w_mis   = is_misaligned(i_ls_addr);
        end else if (w_gnt[0]) begin
            w_any   = 1'b1;
            w_sel   = PORT_IF;
            w_addr  = i_if_addr;
        end else begin
            w_any   = 1'b0;
        end
    end

    assign w_unused_bits = ^{w_addr[31:MEM_AW+2], w_addr[1:0]};

    // read data is only valid in the ack cycle, so it bypasses the hold register then
    assign o_if_rdata  = r_if_ack ? i_mem_rdata : r_if_rdata;
    assign o_ls_rdata  = r_ls_ack ? (r_rd ? i_mem_rdata : 32'd0) : r_ls_rdata;
    assign o_if_ack    = r_if_ack;
    assign o_ls_ack    = r_ls_ack;
    assign o_ls_err    = r_ls_err;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

    // FSM, winner latch and registered memory/response outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_win       <= PORT_IF;
            r_last      <= PORT_IF;
            r_rd        <= 1'b0;
            r_mis       <= 1'b0;
            r_if_ack    <= 1'b0;
            r_ls_ack    <= 1'b0;
            r_ls_err    <= 1'b0;
            r_ld_ack    <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_ls_rdata  <= 32'd0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {MEM_AW{1'b0}};
            r_mem_wdata <= 32'd0;
        end else begin
            r_if_rdata <= o_if_rdata;
            r_ls_rdata <= o_ls_rdata;
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    r_if_ack <= 1'b0;
                    r_ls_ack <= 1'b0;
                    r_ls_err <= 1'b0;
                    r_ld_ack <= 1'b0;
                    if (w_any) begin
                        r_state     <= ST_ISSUE;
                        r_win       <= w_sel;
                        r_rd        <= ~w_we & ~w_mis;
                        r_mis       <= w_mis;
                        r_mem_en    <= ~w_mis;
                        r_mem_we    <= w_we & ~w_mis;
                        r_mem_addr  <= w_addr[MEM_AW+1:2];
                        r_mem_wdata <= w_wdata;
                        if (w_sel != PORT_LD) begin
                            r_last <= w_sel;
                        end else begin
                            r_last <= r_last;
                        end
                    end else begin
                        r_state  <= ST_IDLE;
                        r_mem_en <= 1'b0;
                        r_mem_we <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    r_state  <= ST_RESP;
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_if_ack <= (r_win == PORT_IF);
                    r_ls_ack <= (r_win == PORT_LS);
                    r_ls_err <= (r_win == PORT_LS) & r_mis;
                    r_ld_ack <= (r_win == PORT_LD);
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_if_ack <= 1'b0;
                    r_ls_ack <= 1'b0;
                    r_ls_err <= 1'b0;
                    r_ld_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 64-word synchronous memory model.
// Build with LOADER_PORT_EN defined to also exercise the loader port.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_ack;
    logic        ls_err;
    logic        mem_en;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef LOADER_PORT_EN
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_ack;
`endif

    logic        pl_we;
    logic [5:0]  pl_addr;
    logic [31:0] pl_data;
    logic [31:0] mem [0:63];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_AW(6)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
`ifdef LOADER_PORT_EN
        .i_ld_req    (ld_req),
        .i_ld_addr   (ld_addr),
        .i_ld_wdata  (ld_wdata),
        .o_ld_ack    (ld_ack),
`endif
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_rdata  (if_rdata),
        .o_if_ack    (if_ack),
        .i_ls_req    (ls_req),
        .i_ls_we     (ls_we),
        .i_ls_addr   (ls_addr),
        .i_ls_wdata  (ls_wdata),
        .o_ls_rdata  (ls_rdata),
        .o_ls_ack    (ls_ack),
        .o_ls_err    (ls_err),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    // synchronous memory: read data appears the cycle after mem_en
    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        step();
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'd0; ls_wdata = 32'd0;
`ifdef LOADER_PORT_EN
        ld_req = 1'b0; ld_addr = 32'd0; ld_wdata = 32'd0;
`endif
        pl_we = 1'b1;
        preload(6'd0,  32'h00222000);
        preload(6'd1,  32'h11111111);
        preload(6'd2,  32'h10E60001);
        preload(6'd47, 32'h2F2F2F2F);
        pl_we = 1'b0;
        step();
        chk("rst_mem_en",    mem_en,    32'd0);
        chk("rst_mem_we",    mem_we,    32'd0);
        chk("rst_mem_addr",  mem_addr,  32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_acks",      {if_ack, ls_ack, ls_err}, 32'd0);
        chk("rst_if_rdata",  if_rdata,  32'd0);
        chk("rst_ls_rdata",  ls_rdata,  32'd0);
        rst = 1'b0;

        // single fetch of word 0
        if_req = 1'b1; if_addr = 32'd0;
        step();
        chk("rd_mem_en",   mem_en,   32'd1);
        chk("rd_mem_we",   mem_we,   32'd0);
        chk("rd_mem_addr", mem_addr, 32'd0);
        chk("rd_no_ack",   if_ack,   32'd0);
        step();
        chk("rd_ack",      if_ack,   32'd1);
        chk("rd_data",     if_rdata, 32'h00222000);
        chk("rd_en_low",   mem_en,   32'd0);
        if_req = 1'b0;
        step();
        chk("rd_ack_pulse", if_ack,  32'd0);
        chk("rd_hold",     if_rdata, 32'h00222000);

        // first contention after reset: ls wins, if follows two cycles later
        if_req = 1'b1; if_addr = 32'd0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'd8;
        step();
        chk("c1_ls_addr",  mem_addr, 32'd2);
        step();
        chk("c1_ls_ack",   ls_ack,   32'd1);
        chk("c1_ls_data",  ls_rdata, 32'h10E60001);
        chk("c1_if_wait",  if_ack,   32'd0);
        ls_req = 1'b0;
        step();
        chk("c1_if_en",    mem_en,   32'd1);
        chk("c1_if_addr",  mem_addr, 32'd0);
        step();
        chk("c1_if_ack",   if_ack,   32'd1);
        chk("c1_if_data",  if_rdata, 32'h00222000);
        chk("c1_ls_hold",  ls_rdata, 32'h10E60001);
        if_req = 1'b0;
        step();

        // store to word 3, then load it back (ls becomes last grant)
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'd12; ls_wdata = 32'h1D090001;
        step();
        chk("st_mem_en",   mem_en,    32'd1);
        chk("st_mem_we",   mem_we,    32'd1);
        chk("st_mem_addr", mem_addr,  32'd3);
        chk("st_wdata",    mem_wdata, 32'h1D090001);
        step();
        chk("st_ack",      {ls_ack, ls_err}, 32'd2);
        chk("st_rdata0",   ls_rdata,  32'd0);
        ls_req = 1'b0;
        step();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'd12;
        step();
        step();
        chk("ld_ack",      ls_ack,   32'd1);
        chk("ld_data",     ls_rdata, 32'h1D090001);
        step();
        chk("no_rearb",    mem_en,   32'd0);
        ls_req = 1'b0;
        step();

        // contention with ls granted last: if wins this time
        if_req = 1'b1; if_addr = 32'd0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'd8;
        step();
        chk("c2_if_addr",  mem_addr, 32'd0);
        step();
        chk("c2_if_ack",   {if_ack, ls_ack}, 32'd2);
        if_req = 1'b0;
        step();
        chk("c2_ls_addr",  mem_addr, 32'd2);
        step();
        chk("c2_ls_ack",   ls_ack,   32'd1);
        chk("c2_ls_data",  ls_rdata, 32'h10E60001);
        ls_req = 1'b0;
        step();

        // misaligned store: no memory access, ack with error
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_0006; ls_wdata = 32'hFFFFFFFF;
        step();
        chk("mis_en",      {mem_en, mem_we}, 32'd0);
        step();
        chk("mis_ack_err", {ls_ack, ls_err}, 32'd3);
        ls_req = 1'b0;
        step();
        chk("mis_err_clr", ls_err,   32'd0);

        // fetch ignores low address bits; word 1 left intact
        if_req = 1'b1; if_addr = 32'h0000_0007;
        step();
        step();
        chk("w1_intact",   if_rdata, 32'h11111111);
        if_req = 1'b0;
        step();

        // word address wraps modulo 64
        if_req = 1'b1; if_addr = 32'h0000_00BC;
        step();
        chk("wrap_47",     mem_addr, 32'd47);
        step();
        chk("wrap_47_dat", if_rdata, 32'h2F2F2F2F);
        if_req = 1'b0;
        step();
        if_req = 1'b1; if_addr = 32'h0000_0100;
        step();
        chk("wrap_0",      mem_addr, 32'd0);
        step();
        chk("wrap_0_dat",  if_rdata, 32'h00222000);
        if_req = 1'b0;
        step();

        // reset while a store is in ISSUE
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'd16; ls_wdata = 32'h55AA55AA;
        step();
        chk("rs_issue_we", mem_we,   32'd1);
        rst = 1'b1;
        step();
        chk("rs_no_ack",   {if_ack, ls_ack, ls_err}, 32'd0);
        chk("rs_mem",      {mem_en, mem_we, mem_addr}, 32'd0);
        chk("rs_wdata",    mem_wdata, 32'd0);
        chk("rs_rdata",    {if_rdata | ls_rdata}, 32'd0);
        rst = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        step();

        // last-grant back at if after reset, so ls wins
        if_req = 1'b1; if_addr = 32'd0;
        ls_req = 1'b1; ls_addr = 32'd8;
        step();
        chk("rs_rr_ls",    mem_addr, 32'd2);
        step();
        chk("rs_rr_ack",   {if_ack, ls_ack}, 32'd1);
        ls_req = 1'b0;
        step();
        step();
        chk("rs_rr_if",    if_ack,   32'd1);
        if_req = 1'b0;
        step();

`ifdef LOADER_PORT_EN
        // loader beats ls, misaligned address written without error
        ld_req = 1'b1; ld_addr = 32'd22; ld_wdata = 32'hABCD0000;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'd8;
        step();
        chk("ldp_addr",    mem_addr, 32'd5);
        chk("ldp_we",      mem_we,   32'd1);
        step();
        chk("ldp_ack",     {ld_ack, ls_ack, ls_err}, 32'd4);
        ld_req = 1'b0;
        step();
        chk("ldp_ls_next", mem_addr, 32'd2);
        step();
        chk("ldp_ls_ack",  ls_ack,   32'd1);
        ls_req = 1'b0;
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
